// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Holds the FSM state type, byte-lane names and the byte merge helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

  function automatic logic [31:0] byte_merge(input logic [31:0] oldWord,
                                             input logic [7:0]  byteVal,
                                             input logic [1:0]  lane);
    logic [31:0] merged;
    merged = oldWord;
    case (lane)
      LANE0:   merged[7:0]   = byteVal;
      LANE1:   merged[15:8]  = byteVal;
      LANE2:   merged[23:16] = byteVal;
      default: merged[31:24] = byteVal;
    endcase
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wrEn,
  input  logic [3:0]       byteEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic [31:0]      wrData,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [31:0]      rdData
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wrEn && byteEn[b]) begin
        mem[wrIdx][b*8 +: 8] <= wrData[b*8 +: 8];
      end
    end
  end

  assign rdData = mem[rdIdx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: accept, hold for LATENCY edges, commit, answer once.
// state | meaning
// IDLE  | ready for a request; with LATENCY=1 the accept edge is also the commit edge
// WAIT  | request held, down-counter running toward the commit edge
// RESP  | one-cycle response strobe, then back to IDLE
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t      state, stateNext;
  logic [3:0]  cnt;
  logic        heldWe, heldByte;
  logic [31:0] heldAddr, heldWdata;

  logic        accept, commit;
  logic        curWe, curByte, curErr;
  logic [31:0] curAddr, curWdata;
  logic [1:0]  curLane;
  logic [31:0] rdWord, wrWord;
  logic [3:0]  byteEn;
  logic        wrEn;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    stateNext = state;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            stateNext = RESP;
            commit    = 1'b1;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          stateNext = RESP;
          commit    = 1'b1;
        end
      end
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Only a LATENCY=1 build commits from IDLE, where the request is still on the live inputs.
  always_comb begin
    if (state == IDLE) begin
      curWe    = req_we;
      curByte  = req_byte;
      curAddr  = req_addr;
      curWdata = req_wdata;
    end else begin
      curWe    = heldWe;
      curByte  = heldByte;
      curAddr  = heldAddr;
      curWdata = heldWdata;
    end
  end

  assign curLane = curAddr[1:0];
  assign curErr  = (curAddr[31:IDX_W+2] != '0) || (!curByte && (curLane != LANE0));
  assign wrEn    = commit && curWe && !curErr;
  assign byteEn  = curByte ? (4'b0001 << curLane) : 4'b1111;
  assign wrWord  = curByte ? byte_merge(rdWord, curWdata[7:0], curLane) : curWdata;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .wrEn  (wrEn),
    .byteEn(byteEn),
    .wrIdx (curAddr[IDX_W+1:2]),
    .wrData(wrWord),
    .rdIdx (curAddr[IDX_W+1:2]),
    .rdData(rdWord)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      heldWe    <= 1'b0;
      heldByte  <= 1'b0;
      heldAddr  <= 32'd0;
      heldWdata <= 32'd0;
    end else if (accept) begin
      cnt       <= 4'(LATENCY - 1);
      heldWe    <= req_we;
      heldByte  <= req_byte;
      heldAddr  <= req_addr;
      heldWdata <= req_wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= commit;
      if (commit) begin
        resp_rdata <= (curErr || curWe) ? 32'd0 : rdWord;
        resp_err   <= curErr;
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder serving the pipelined datapath's memory-stage load/store requests.
- Accepts one word or byte access per handshake.
- Holds it for a fixed access latency, commits it to a local word-organised RAM, and returns one response beat.
- Byte stores arrive with the store byte already in wdata[7:0]; the responder places it in the lane selected by addr[1:0].
- Byte loads return the full word; lane extraction stays in the writeback stage.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the RAM (power of two, 2..1024)
LATENCY, 2, edges from request acceptance to response (1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_byte  input  1  1 = byte access, 0 = word access
req_addr  input  32  byte address
req_wdata  input  32  store data; for byte stores only [7:0] is meaningful
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  load data; 0 for stores and errors
resp_err  output  1  qualifies resp_valid; access rejected

Behaviour:
- States: IDLE, WAIT, RESP.
- req_ready = (state == IDLE), decoded combinationally from state.
- Acceptance: req_valid & req_ready at a rising edge. Capture we, byte, addr and wdata into holding registers. Load the down-counter with LATENCY-1.
  - LATENCY = 1: go IDLE→RESP.
  - Otherwise: go IDLE→WAIT.
- WAIT: counter decrements each edge. On the edge where the counter is 1, go to RESP.
- Commit edge is the IDLE/WAIT→RESP edge. At that edge:
  - Stores are written.
  - resp_rdata and resp_err are registered.
  - resp_valid rises.
- Timing: request accepted at edge N gives resp_valid high during the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- RESP lasts exactly one cycle, then IDLE. Throughput is one access per LATENCY+1 cycles.
- req_valid outside IDLE is ignored. The requester holds it; no queueing.
- Word index = addr[log2(DEPTH_WORDS)+1:2]; lane = addr[1:0].
- Error when either holds:
  - addr >= 4*DEPTH_WORDS.
  - Word access with addr[1:0] != 0.
- On error: no RAM write, resp_rdata = 0, resp_err = 1.
- Word store: mem[idx] <= wdata.
- Byte store: only byte lane `lane` of mem[idx] <= wdata[7:0]. The other three bytes are unchanged.
- Load (word or byte): resp_rdata = mem[idx] as it was before the commit edge.
- Store response: resp_rdata = 0, resp_err = 0.
- Outputs change only on clock edges, except req_ready, which is combinational from state.
- Reset (reset = 0, asynchronous):
  - state = IDLE, counter = 0.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - req_ready = 1 while in reset.
- RAM contents are not reset.
- Reset mid-operation: the in-flight request is discarded, no write is committed and no response is issued.
- First acceptance is possible on the first rising edge after reset deasserts.

Decomposition:
- Package dmem_pkg:
  - State enum type (IDLE, WAIT, RESP).
  - Lane constants LANE0..LANE3.
  - Function byte_merge(old_word, byte, lane) returning the merged 32-bit word.
- One sub-module, dmem_array:
  - DEPTH_WORDS x 32 storage.
  - Synchronous write with 4-bit byte enable.
  - Combinational read by index.
  - No reset.
- FSM, counter, holding registers and error check live in dmem_responder.

Test Plan:
1. LATENCY=2. Word store addr 0x10 data 0xDEADBEEF, then word load 0x10 -> store response resp_err=0, rdata=0. Load resp_valid exactly 2 cycles after acceptance with rdata 0xDEADBEEF. req_ready low for 2 cycles after each acceptance.
2. After test 1, byte store addr 0x12 wdata 0xFFFFFF55, then word load 0x10 -> rdata 0xDE55BEEF. Upper bits of wdata are ignored.
3. Word load addr 0x11 -> resp_err=1, rdata=0. Word load addr 0x100 (DEPTH_WORDS=64) -> resp_err=1. RAM unchanged: reload 0x10 still gives 0xDE55BEEF.
4. req_valid held high continuously with 3 back-to-back loads -> exactly 3 responses, one every LATENCY+1 cycles, addresses in order. No request accepted while in WAIT or RESP.
5. Byte store 0x10 data 0x00 accepted, then reset pulsed low for half a cycle in WAIT -> no resp_valid. Load 0x10 after reset returns 0xDE55BEEF, proving the write was dropped. All outputs 0 and req_ready=1 during reset.
6. LATENCY=1 build: word store 0x04 data 0x12345678 then load 0x04 -> each resp_valid one cycle after acceptance. Load returns 0x12345678. IDLE→RESP→IDLE with no WAIT.
